iter_mult_unit: RTL and testbench



---
 rtl/iter_mult_unit.sv | 183 ++++++++++++++++++
 tb/tb_iter_mult_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_mult_unit.sv
// Multi-cycle radix-2 shift-add multiplier with MUL, MLA, SMULL and POW modes.
// Operands arrive on a four-phase req/ack handshake; results are held until the next completion.
module iter_mult_unit #(
    parameter int WIDTH = 32,
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    output logic             ack,
    output logic             busy,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] rm,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rn,
    input  logic [EXP_W-1:0] exp,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] MODE_MUL   = 2'b00;
    localparam logic [1:0] MODE_MLA   = 2'b01;
    localparam logic [1:0] MODE_SMULL = 2'b10;
    localparam logic [1:0] MODE_POW   = 2'b11;

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t             state_q;
    logic [1:0]         mode_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [EXP_W-1:0]   pow_left_q;
    logic [WIDTH-1:0]   base_q;
    logic               neg_q;
    logic               pow_ovf_q;
    logic               ack_q;
    logic               busy_q;
    logic [WIDTH-1:0]   res_lo_q;
    logic [WIDTH-1:0]   res_hi_q;
    logic               ovf_q;
    logic               zero_q;

    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] signed_d;
    logic [CNT_W-1:0]   cnt_d;
    logic [WIDTH-1:0]   rm_mag;
    logic [WIDTH-1:0]   rs_mag;

    always_comb begin
        acc_d    = acc_q + (mplier_q[0] ? mcand_q : {2*WIDTH{1'b0}});
        cnt_d    = cnt_q - CNT_W'(1);
        signed_d = neg_q ? (-acc_d) : acc_d;
        // SMULL runs on magnitudes; the most negative value is its own magnitude when read unsigned
        rm_mag   = rm[WIDTH-1] ? (-rm) : rm;
        rs_mag   = rs[WIDTH-1] ? (-rs) : rs;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_MUL;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            pow_left_q <= '0;
            base_q     <= '0;
            neg_q      <= 1'b0;
            pow_ovf_q  <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            res_lo_q   <= '0;
            res_hi_q   <= '0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        mode_q     <= mode;
                        base_q     <= rm;
                        cnt_q      <= CNT_W'(WIDTH);
                        pow_left_q <= exp - EXP_W'(1);
                        pow_ovf_q  <= 1'b0;
                        neg_q      <= (mode == MODE_SMULL) && (rm[WIDTH-1] ^ rs[WIDTH-1]);
                        acc_q      <= (mode == MODE_MLA) ? {{WIDTH{1'b0}}, rn} : '0;
                        case (mode)
                            MODE_SMULL: begin
                                mcand_q  <= {{WIDTH{1'b0}}, rm_mag};
                                mplier_q <= rs_mag;
                            end
                            MODE_POW: begin
                                mcand_q  <= {{WIDTH{1'b0}}, rm};
                                mplier_q <= rm;
                            end
                            default: begin
                                mcand_q  <= {{WIDTH{1'b0}}, rm};
                                mplier_q <= rs;
                            end
                        endcase
                        if (mode == MODE_POW && exp <= EXP_W'(1)) begin
                            // x^0 and x^1 need no multiply, so finish on the capture edge
                            state_q  <= DONE;
                            ack_q    <= 1'b1;
                            res_lo_q <= (exp == '0) ? WIDTH'(1) : rm;
                            res_hi_q <= '0;
                            ovf_q    <= 1'b0;
                            zero_q   <= (exp != '0) && (rm == '0);
                        end else begin
                            state_q <= MULT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_d;
                    if (cnt_d == '0) begin
                        if (mode_q == MODE_POW && pow_left_q > EXP_W'(1)) begin
                            // feed the truncated product back in as the next multiplier
                            acc_q      <= '0;
                            mcand_q    <= {{WIDTH{1'b0}}, base_q};
                            mplier_q   <= acc_d[WIDTH-1:0];
                            cnt_q      <= CNT_W'(WIDTH);
                            pow_left_q <= pow_left_q - EXP_W'(1);
                            pow_ovf_q  <= pow_ovf_q | (acc_d[2*WIDTH-1:WIDTH] != '0);
                        end else begin
                            state_q <= DONE;
                            ack_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            case (mode_q)
                                MODE_SMULL: begin
                                    res_lo_q <= signed_d[WIDTH-1:0];
                                    res_hi_q <= signed_d[2*WIDTH-1:WIDTH];
                                    ovf_q    <= signed_d[2*WIDTH-1:WIDTH] != {WIDTH{signed_d[WIDTH-1]}};
                                    zero_q   <= acc_d == '0;
                                end
                                MODE_POW: begin
                                    res_lo_q <= acc_d[WIDTH-1:0];
                                    res_hi_q <= '0;
                                    ovf_q    <= pow_ovf_q | (acc_d[2*WIDTH-1:WIDTH] != '0);
                                    zero_q   <= acc_d[WIDTH-1:0] == '0;
                                end
                                default: begin
                                    res_lo_q <= acc_d[WIDTH-1:0];
                                    res_hi_q <= acc_d[2*WIDTH-1:WIDTH];
                                    ovf_q    <= acc_d[2*WIDTH-1:WIDTH] != '0;
                                    zero_q   <= acc_d == '0;
                                end
                            endcase
                        end
                    end
                end
                DONE: begin
                    if (!req) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_iter_mult_unit.sv
// Self-checking bench for iter_mult_unit: directed vector table, handshake corner cases
// and randomized operations compared against an arithmetic reference model.
module tb_iter_mult_unit;

    localparam int W  = 32;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [1:0]    mode;
    logic [W-1:0]  rm, rs, rn;
    logic [EW-1:0] exp;
    logic          ack, busy, overflow, zero;
    logic [W-1:0]  result_lo, result_hi;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic [31:0] a, b, c;
        logic [3:0]  e;
        logic [31:0] lo, hi;
        logic        ov, z;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    iter_mult_unit #(.WIDTH(W), .EXP_W(EW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
        .mode(mode), .rm(rm), .rs(rs), .rn(rn), .exp(exp),
        .result_lo(result_lo), .result_hi(result_hi),
        .overflow(overflow), .zero(zero)
    );

    // Reference model: plain 64-bit arithmetic straight from the mode definitions
    function automatic void model(input logic [1:0] m, input logic [31:0] a, b, c,
                                  input logic [3:0] e, output logic [31:0] lo, hi,
                                  output logic ov, z, output int lat);
        logic [63:0] p;
        logic [31:0] r;
        ov  = 1'b0;
        lat = 32;
        p   = '0;
        case (m)
            2'b00: p = {32'b0, a} * {32'b0, b};
            2'b01: p = {32'b0, a} * {32'b0, b} + {32'b0, c};
            2'b10: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
            default: begin
                if (e == 0) r = 32'd1;
                else        r = a;
                for (int i = 1; i < int'(e); i++) begin
                    p = {32'b0, r} * {32'b0, a};
                    if (p[63:32] != 0) ov = 1'b1;
                    r = p[31:0];
                end
                p   = {32'b0, r};
                lat = (e <= 1) ? 0 : (int'(e) - 1) * 32;
            end
        endcase
        lo = p[31:0];
        hi = p[63:32];
        if (m == 2'b00 || m == 2'b01) ov = (hi != 0);
        if (m == 2'b10)               ov = (hi != {32{lo[31]}});
        z = (p == 0);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one request and waits for ack; inputs are scrambled after capture to prove they are ignored
    task automatic applyStimulus(input logic [1:0] m, input logic [31:0] a, b, c, input logic [3:0] e,
                                 output int lat, output int busyLow);
        @(negedge clk);
        mode = m; rm = a; rs = b; rn = c; exp = e; req = 1'b1;
        lat = -1;
        busyLow = 0;
        for (int n = 0; n < 1000; n++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                lat = n;
                break;
            end
            if (!busy) busyLow++;
            mode = 2'($urandom); rm = $urandom; rs = $urandom; rn = $urandom; exp = 4'($urandom);
        end
    endtask

    task automatic releaseReq(input string name, input logic [31:0] expLo);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, " ack fall"}, 64'(ack), 64'd0);
        checkOutput({name, " held lo"}, 64'(result_lo), 64'(expLo));
    endtask

    task automatic runOp(input string name, input logic [1:0] m, input logic [31:0] a, b, c,
                         input logic [3:0] e, input logic [31:0] lo, hi, input logic ov, z, input int lat);
        int gotLat, busyLow;
        applyStimulus(m, a, b, c, e, gotLat, busyLow);
        checkOutput({name, " latency"}, 64'(gotLat), 64'(lat));
        checkOutput({name, " lo"}, 64'(result_lo), 64'(lo));
        checkOutput({name, " hi"}, 64'(result_hi), 64'(hi));
        checkOutput({name, " overflow"}, 64'(overflow), 64'(ov));
        checkOutput({name, " zero"}, 64'(zero), 64'(z));
        checkOutput({name, " busy gaps"}, 64'(busyLow), 64'd0);
        releaseReq(name, lo);
    endtask

    initial begin
        int gotLat, busyLow, ackLow, loChanged;
        logic [31:0] eLo, eHi;
        logic eOv, eZ;
        int eLat;

        vecs[0]  = '{"mul7x6",     2'b00, 32'd7,        32'd6,        32'd0,        4'd0,  32'd42,       32'd0,        1'b0, 1'b0, 32};
        vecs[1]  = '{"mla_ones",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'd0,  32'h0,        32'hFFFFFFFF, 1'b1, 1'b0, 32};
        vecs[2]  = '{"smull_m3x5", 2'b10, 32'hFFFFFFFD, 32'd5,        32'd0,        4'd0,  32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
        vecs[3]  = '{"smull_zero", 2'b10, 32'd0,        32'h80000000, 32'd0,        4'd0,  32'd0,        32'd0,        1'b0, 1'b1, 32};
        vecs[4]  = '{"pow2_10",    2'b11, 32'd2,        32'd0,        32'd0,        4'd10, 32'd1024,     32'd0,        1'b0, 1'b0, 288};
        vecs[5]  = '{"pow2_0",     2'b11, 32'd2,        32'd0,        32'd0,        4'd0,  32'd1,        32'd0,        1'b0, 1'b0, 0};
        vecs[6]  = '{"pow_ovf",    2'b11, 32'h10000,    32'd0,        32'd0,        4'd3,  32'd0,        32'd0,        1'b1, 1'b1, 64};
        vecs[7]  = '{"pow5_1",     2'b11, 32'd5,        32'd0,        32'd0,        4'd1,  32'd5,        32'd0,        1'b0, 1'b0, 0};
        vecs[8]  = '{"pow3_15",    2'b11, 32'd3,        32'd0,        32'd0,        4'd15, 32'd14348907, 32'd0,        1'b0, 1'b0, 448};
        vecs[9]  = '{"mul_carry",  2'b00, 32'hFFFFFFFF, 32'd2,        32'd0,        4'd0,  32'hFFFFFFFE, 32'd1,        1'b1, 1'b0, 32};
        vecs[10] = '{"smull_min",  2'b10, 32'h80000000, 32'h80000000, 32'd0,        4'd0,  32'd0,        32'h40000000, 1'b1, 1'b0, 32};
        vecs[11] = '{"smull_m1",   2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        4'd0,  32'd1,        32'd0,        1'b0, 1'b0, 32};

        rst_n = 1'b0; req = 1'b0; mode = '0; rm = '0; rs = '0; rn = '0; exp = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset flags", 64'({ack, busy, overflow, zero}), 64'd0);
        checkOutput("reset lo", 64'(result_lo), 64'd0);
        checkOutput("reset hi", 64'(result_hi), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            runOp(vecs[i].name, vecs[i].m, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e,
                  vecs[i].lo, vecs[i].hi, vecs[i].ov, vecs[i].z, vecs[i].lat);

        // req held high past ack: ack must stay up and nothing is recaptured
        applyStimulus(2'b00, 32'd7, 32'd6, 32'd0, 4'd0, gotLat, busyLow);
        checkOutput("hold latency", 64'(gotLat), 64'd32);
        ackLow = 0;
        loChanged = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rm = 32'd100; rs = 32'd100;
            @(posedge clk);
            #1;
            if (!ack || busy) ackLow++;
            if (result_lo != 32'd42) loChanged++;
        end
        checkOutput("hold ack high", 64'(ackLow), 64'd0);
        checkOutput("hold no recapture", 64'(loChanged), 64'd0);
        releaseReq("hold", 32'd42);

        // synchronous reset in the middle of a multiply
        @(negedge clk);
        mode = 2'b00; rm = 32'd12345; rs = 32'd777; req = 1'b1;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midreset flags", 64'({ack, busy, overflow, zero}), 64'd0);
        checkOutput("midreset lo", 64'(result_lo), 64'd0);
        checkOutput("midreset hi", 64'(result_hi), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        runOp("after_reset", 2'b00, 32'd3, 32'd3, 32'd0, 4'd0, 32'd9, 32'd0, 1'b0, 1'b0, 32);

        // req dropped during MULT: the operation finishes with a single-cycle ack
        @(negedge clk);
        mode = 2'b00; rm = 32'd11; rs = 32'd13; req = 1'b1;
        gotLat = -1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (ack) begin
                gotLat = n;
                break;
            end
            if (n == 4) req = 1'b0;
        end
        checkOutput("drop latency", 64'(gotLat), 64'd32);
        checkOutput("drop lo", 64'(result_lo), 64'd143);
        @(posedge clk);
        #1;
        checkOutput("drop ack one cycle", 64'(ack), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("drop stays idle", 64'({ack, busy}), 64'd0);
        runOp("after_drop", 2'b01, 32'd5, 32'd6, 32'd7, 4'd0, 32'd37, 32'd0, 1'b0, 1'b0, 32);

        // randomized operations against the reference model
        for (int k = 0; k < 30; k++) begin
            logic [1:0]  m;
            logic [31:0] a, b, c;
            logic [3:0]  e;
            m = 2'($urandom_range(0, 3));
            a = (k % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            b = $urandom;
            c = $urandom;
            e = 4'($urandom_range(0, 15));
            model(m, a, b, c, e, eLo, eHi, eOv, eZ, eLat);
            runOp($sformatf("rand%0d", k), m, a, b, c, e, eLo, eHi, eOv, eZ, eLat);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
